// File: rtl/ddr3_read_capture_ctrl_if.sv
// Read-capture bundle between the DDR3 read sequencer and its ring-buffer drain controller.
// The slave side is the controller; the master side issues reads and supplies buffer data.
interface ddr3_read_capture_ctrl_if #(parameter int DATA_W = 16);
  logic              rd_req;
  logic [3:0]        cl;
  logic              flush;
  logic [DATA_W-1:0] buf_dout;
  logic              ready;
  logic              listen;
  logic [2:0]        readPtr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_last;
  logic              rd_err;

  modport master (
    output rd_req, cl, flush, buf_dout,
    input  ready, listen, readPtr, rd_data, rd_valid, rd_last, rd_err
  );

  modport slave (
    input  rd_req, cl, flush, buf_dout,
    output ready, listen, readPtr, rd_data, rd_valid, rd_last, rd_err
  );
endinterface

// File: rtl/ddr3_read_capture_ctrl.sv
// DDR3 read capture: waits CAS latency, arms the strobe filter, settles, drains 8 words.
// Latency rd_req->first rd_valid is cl+2+SETTLE_CYC; busy requests are dropped with rd_err.
module ddr3_read_capture_ctrl #(
  parameter int DATA_W     = 16,
  parameter int SETTLE_CYC = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  ddr3_read_capture_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WAIT_CL, LISTEN, SETTLE, DRAIN} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic [3:0]        cl_eff;

  // The DRAM cannot return data sooner than two clocks after the command.
  always_comb cl_eff = (bus.cl < 4'd2) ? 4'd2 : bus.cl;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    err_d   = bus.rd_req && !bus.flush && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (bus.rd_req) begin
          state_d = WAIT_CL;
          cnt_d   = cl_eff - 4'd2;
        end
      end
      WAIT_CL: begin
        if (cnt_q == 4'd0) state_d = LISTEN;
        else               cnt_d   = cnt_q - 4'd1;
      end
      LISTEN: begin
        state_d = SETTLE;
        cnt_d   = SETTLE_LOAD;
      end
      SETTLE: begin
        if (cnt_q == 4'd0) state_d = DRAIN;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DRAIN: begin
        data_d  = bus.buf_dout;
        valid_d = 1'b1;
        last_d  = (ptr_q == 3'd7);
        ptr_d   = ptr_q + 3'd1;
        if (ptr_q == 3'd7) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush also squashes the word captured this cycle so nothing leaks out afterwards.
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      ptr_d   = 3'd0;
      data_d  = data_q;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ptr_q   <= 3'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign bus.ready    = (state_q == IDLE);
  assign bus.listen   = (state_q == LISTEN);
  assign bus.readPtr  = ptr_q;
  assign bus.rd_data  = data_q;
  assign bus.rd_valid = valid_q;
  assign bus.rd_last  = last_q;
  assign bus.rd_err   = err_q;
endmodule

// File: tb/tb_ddr3_read_capture_ctrl.sv
// Self-checking bench for ddr3_read_capture_ctrl against a burst-level timing model.
module tb_ddr3_read_capture_ctrl;
  localparam int DATA_W = 16;
  localparam int S      = 3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ddr3_read_capture_ctrl_if #(.DATA_W(DATA_W)) bus ();

  ddr3_read_capture_ctrl #(.DATA_W(DATA_W), .SETTLE_CYC(S)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [DATA_W-1:0] data_base;
  assign bus.buf_dout = data_base + DATA_W'(bus.readPtr);

  int checks;
  int errors;
  int cyc;

  // Model: each accepted burst is (accept cycle, effective latency, flush cycle).
  int b_t[$];
  int b_l[$];
  int b_f[$];
  int err_c[$];

  typedef struct packed {
    logic       ready;
    logic       listen;
    logic [2:0] ptr;
    logic       valid;
    logic       last;
    logic       err;
    logic [2:0] k;
  } exp_t;

  function automatic bit busy(int c);
    for (int i = 0; i < b_t.size(); i++)
      if (c > b_t[i] && c <= b_t[i] + b_l[i] + S + 8 && c <= b_f[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t model(int c);
    exp_t e;
    int   d;
    e = '0;
    e.ready = !busy(c);
    for (int i = 0; i < b_t.size(); i++) begin
      if (c <= b_f[i]) begin
        d = c - (b_t[i] + b_l[i]);
        if (d == 0) e.listen = 1'b1;
        if (d - 1 - S >= 0 && d - 1 - S <= 7) e.ptr = 3'(d - 1 - S);
        if (d - 2 - S >= 0 && d - 2 - S <= 7) begin
          e.valid = 1'b1;
          e.k     = 3'(d - 2 - S);
          e.last  = (d - 2 - S == 7);
        end
      end
    end
    foreach (err_c[i]) if (err_c[i] == c) e.err = 1'b1;
    return e;
  endfunction

  function automatic logic [7:0] exp_vec(exp_t e);
    return {e.ready, e.listen, e.ptr, e.valid, e.last, e.err};
  endfunction

  function automatic logic [7:0] obs_vec();
    return {bus.ready, bus.listen, bus.readPtr, bus.rd_valid, bus.rd_last, bus.rd_err};
  endfunction

  task automatic clear_model();
    b_t.delete(); b_l.delete(); b_f.delete(); err_c.delete();
    cyc = 0;
  endtask

  // Drive inputs for the current cycle and record what the controller should do with them.
  task automatic drive(bit req, int clv, bit fl);
    bus.rd_req = req;
    bus.cl     = 4'(clv);
    bus.flush  = fl;
    if (fl) begin
      foreach (b_f[i]) if (b_f[i] > cyc) b_f[i] = cyc;
    end else if (req) begin
      if (!busy(cyc)) begin
        b_t.push_back(cyc);
        b_l.push_back(clv < 2 ? 2 : clv);
        b_f.push_back(1 << 30);
      end else begin
        err_c.push_back(cyc + 1);
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    bus.rd_req  = 1'b1;
    bus.cl      = 4'd4;
    bus.flush   = 1'b0;
    data_base   = 16'h1234;
    #22;
    checks++;
    if (obs_vec() !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_state got=%b want=%b", obs_vec(), 8'b1000_0000);
    end
    checks++;
    if (bus.rd_data !== '0) begin
      errors++;
      $display("FAIL reset_data got=%h want=0", bus.rd_data);
    end
    bus.rd_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    clear_model();
  endtask

  task automatic test_basic_b2b_busy();
    exp_t e;
    data_base = 16'hA000;
    for (int c = 0; c < 36; c++) begin
      drive(c == 0 || c == 6 || c == 16,
            c == 0 ? 4 : (c == 16 ? 2 : int'($urandom_range(0, 15))), 1'b0);
      @(negedge clk);
      e = model(cyc);
      checks++;
      if (obs_vec() !== exp_vec(e)) begin
        errors++;
        $display("FAIL basic cyc=%0d rdy/lis/ptr/vld/last/err got=%b want=%b", cyc, obs_vec(), exp_vec(e));
      end
      if (e.valid) begin
        checks++;
        if (bus.rd_data !== data_base + DATA_W'(e.k)) begin
          errors++;
          $display("FAIL basic_data cyc=%0d got=%h want=%h", cyc, bus.rd_data, data_base + DATA_W'(e.k));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_flush();
    exp_t e;
    bit   rq, fl;
    clear_model();
    data_base = 16'($urandom);
    for (int c = 0; c < 56; c++) begin
      rq = (c == 0 || c == 13 || c == 15 || c == 18 || c == 22);
      fl = (c == 10 || c == 13 || c == 18);
      drive(rq, c == 0 ? 3 : (c == 15 ? 5 : int'($urandom_range(0, 15))), fl);
      @(negedge clk);
      e = model(cyc);
      checks++;
      if (obs_vec() !== exp_vec(e)) begin
        errors++;
        $display("FAIL flush cyc=%0d rdy/lis/ptr/vld/last/err got=%b want=%b", cyc, obs_vec(), exp_vec(e));
      end
      if (e.valid) begin
        checks++;
        if (bus.rd_data !== data_base + DATA_W'(e.k)) begin
          errors++;
          $display("FAIL flush_data cyc=%0d got=%h want=%h", cyc, bus.rd_data, data_base + DATA_W'(e.k));
        end
      end
      next_cycle();
    end
    bus.flush = 1'b0;
  endtask

  task automatic test_min_latency();
    exp_t e;
    clear_model();
    data_base = 16'($urandom);
    for (int c = 0; c < 40; c++) begin
      drive(c == 0 || c == 20, c == 0 ? 0 : (c == 20 ? 1 : int'($urandom_range(0, 15))), 1'b0);
      @(negedge clk);
      e = model(cyc);
      checks++;
      if (obs_vec() !== exp_vec(e)) begin
        errors++;
        $display("FAIL min_lat cyc=%0d rdy/lis/ptr/vld/last/err got=%b want=%b", cyc, obs_vec(), exp_vec(e));
      end
      if (e.valid) begin
        checks++;
        if (bus.rd_data !== data_base + DATA_W'(e.k)) begin
          errors++;
          $display("FAIL min_lat_data cyc=%0d got=%h want=%h", cyc, bus.rd_data, data_base + DATA_W'(e.k));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    exp_t e;
    bit   rq, fl;
    clear_model();
    data_base = 16'($urandom);
    for (int c = 0; c < 400; c++) begin
      rq = (c < 360) && ($urandom_range(0, 5) == 0);
      fl = (c < 360) && ($urandom_range(0, 39) == 0);
      drive(rq, int'($urandom_range(0, 15)), fl);
      @(negedge clk);
      e = model(cyc);
      checks++;
      if (obs_vec() !== exp_vec(e)) begin
        errors++;
        $display("FAIL random cyc=%0d rdy/lis/ptr/vld/last/err got=%b want=%b", cyc, obs_vec(), exp_vec(e));
      end
      if (e.valid) begin
        checks++;
        if (bus.rd_data !== data_base + DATA_W'(e.k)) begin
          errors++;
          $display("FAIL random_data cyc=%0d got=%h want=%h", cyc, bus.rd_data, data_base + DATA_W'(e.k));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    clear_model();
    data_base = 16'($urandom);
    // Burst with cl=2 sits in SETTLE during cycles 3..5; reset lands inside cycle 4.
    for (int c = 0; c < 5; c++) begin
      drive(c == 0, 2, 1'b0);
      @(negedge clk);
      e = model(cyc);
      checks++;
      if (obs_vec() !== exp_vec(e)) begin
        errors++;
        $display("FAIL async_pre cyc=%0d rdy/lis/ptr/vld/last/err got=%b want=%b", cyc, obs_vec(), exp_vec(e));
      end
      if (c < 4) next_cycle();
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== 8'b1000_0000) begin
      errors++;
      $display("FAIL async_reset_state got=%b want=%b", obs_vec(), 8'b1000_0000);
    end
    checks++;
    if (bus.rd_data !== '0) begin
      errors++;
      $display("FAIL async_reset_data got=%h want=0", bus.rd_data);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    clear_model();
    for (int c = 0; c < 22; c++) begin
      drive(c == 2, 2, 1'b0);
      @(negedge clk);
      e = model(cyc);
      checks++;
      if (obs_vec() !== exp_vec(e)) begin
        errors++;
        $display("FAIL async_post cyc=%0d rdy/lis/ptr/vld/last/err got=%b want=%b", cyc, obs_vec(), exp_vec(e));
      end
      if (e.valid) begin
        checks++;
        if (bus.rd_data !== data_base + DATA_W'(e.k)) begin
          errors++;
          $display("FAIL async_post_data cyc=%0d got=%h want=%h", cyc, bus.rd_data, data_base + DATA_W'(e.k));
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    reset_n    = 1'b0;
    bus.rd_req = 1'b0;
    bus.cl     = 4'd0;
    bus.flush  = 1'b0;
    data_base  = '0;
    test_reset();
    test_basic_b2b_busy();
    test_flush();
    test_min_latency();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ddr3_read_capture_ctrl.md
DDR3_READ_CAPTURE_CTRL -- requirements
Module: ddr3_read_capture_ctrl

Interface
REQ-001 Parameter DATA_W, default 16: width of the ring buffer data path.
REQ-002 Parameter SETTLE_CYC, default 3, legal range 1..15: clocks from listen until the drain starts, covering strobe delay and the 4-edge-pair capture.
REQ-003 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port rd_req  input  1  read command issued to the DRAM this cycle; accepted only when ready=1.
REQ-006 Port cl  input  4  CAS latency in clocks; sampled only in the acceptance cycle.
REQ-007 Port flush  input  1  synchronous abort of any read in progress.
REQ-008 Port buf_dout  input  DATA_W  ring buffer output, selected combinationally by readPtr.
REQ-009 Port ready  output  1  controller idle; able to accept rd_req.
REQ-010 Port listen  output  1  one-clock arm pulse to the ring buffer strobe filter.
REQ-011 Port readPtr  output  3  ring buffer read pointer, registered.
REQ-012 Port rd_data  output  DATA_W  drained word, registered.
REQ-013 Port rd_valid  output  1  rd_data holds a valid word this cycle.
REQ-014 Port rd_last  output  1  rd_data holds word 7 of the burst.
REQ-015 Port rd_err  output  1  one-clock pulse: a rd_req arrived while ready=0 and was dropped.

Function
REQ-016 The state machine SHALL have five states: IDLE, WAIT_CL, LISTEN, SETTLE and DRAIN; ready SHALL be 1 only in IDLE.
REQ-017 IDLE with rd_req=1 and flush=0 SHALL enter WAIT_CL and load the latency counter from cl, where any cl value below 2 is treated as 2.
REQ-018 WAIT_CL SHALL decrement the latency counter so that LISTEN is entered in cycle T+cl, where T is the acceptance cycle.
REQ-019 LISTEN SHALL last exactly one cycle with listen=1; listen SHALL be 0 in every other state.
REQ-020 SETTLE SHALL last exactly SETTLE_CYC cycles, with readPtr held at 0.
REQ-021 DRAIN SHALL last 8 cycles, with readPtr = 0,1,...,7 in successive cycles; after readPtr=7 the block SHALL return to IDLE.
REQ-022 rd_data SHALL register buf_dout, with rd_valid=1 exactly one cycle after each DRAIN cycle, so the data latency from readPtr to rd_data is 1 clock.
REQ-023 rd_last SHALL equal 1 only together with the rd_valid of the word from readPtr=7.
REQ-024 The timing from an accepted rd_req at T SHALL be: listen at T+cl; readPtr=k at T+cl+1+SETTLE_CYC+k; rd_valid at T+cl+2+SETTLE_CYC+k.
REQ-025 A new rd_req SHALL be acceptable in the cycle carrying rd_last, since ready=1 there, giving back-to-back bursts with no dead cycle.
REQ-026 rd_req while ready=0 SHALL be dropped, and rd_err SHALL be set to 1 in the next cycle only; the current burst SHALL be unaffected.
REQ-027 flush=1 in cycle F SHALL put the block in IDLE at F+1, with readPtr=0, listen=0, and rd_valid/rd_last=0 from F+1 onward, including any word already in the pipeline.
REQ-028 If flush and rd_req are high in the same cycle, flush SHALL win: the request is dropped and rd_err stays 0.
REQ-029 Changes on cl outside the acceptance cycle SHALL have no effect on the burst in progress.

Reset
REQ-030 reset_n=0 SHALL immediately force: state IDLE, ready=1, listen=0, readPtr=0, rd_data=0, rd_valid=0, rd_last=0, rd_err=0, and all counters 0.
REQ-031 A reset during any state SHALL abandon the burst with no further listen or rd_valid; operation SHALL resume on the first rising edge after reset_n=1.

Verification
REQ-032 Basic burst: cl=4, SETTLE_CYC=3, rd_req at cycle 0, buf_dout=0xA000+readPtr -> listen only at cycle 4; readPtr 0..7 at cycles 8..15; rd_data 0xA000..0xA007 valid at cycles 9..16; rd_last at 16.
REQ-033 Back-to-back: second rd_req in cycle 16 with cl=2 -> accepted with no rd_err; listen at 18; rd_valid cycles 23..30.
REQ-034 Busy request: rd_req at cycle 6 during the first burst -> rd_err=1 in cycle 7 only; the first burst completes unchanged; no extra listen.
REQ-035 Flush: flush at cycle 11 during DRAIN -> ready=1 and rd_valid=0 from cycle 12; no rd_last; flush with rd_req together -> no accept and no rd_err.
REQ-036 Async reset: reset_n low mid-SETTLE, between clock edges -> all outputs reach their reset values immediately; no rd_valid afterwards.
REQ-037 Minimum latency: cl=0 and cl=1 -> each behaves identically to cl=2, with listen at T+2.
